// File: rtl/mul_div_unit.sv
// Purpose: EXE-stage iterative multiply/divide engine (MULT, MULTU, DIV, DIVU) producing HI/LO.
// Latency: multiply busy 1+MUL_LATENCY cycles, divide busy 33 cycles; result held in DONE.
// Backpressure: DIVMULTBusy freezes the pipeline; the result is held until EXE_Wr or a flush.
//
// Ports:
//   clk, resetn            core clock, synchronous active-low reset
//   EXE_MulDivOp[2:0]      0=none 1=MULT 2=MULTU 3=DIV 4=DIVU (5..7 = none)
//   EXE_SrcA/EXE_SrcB      rs / rt operands, latched on accept
//   EXE_Wr                 EXE stage advances (releases a held result)
//   Flush_Exception        cancels any operation, returns to IDLE
//   DIVMULTBusy            combinational stall request
//   MulDiv_Hi/MulDiv_Lo    HI (product high / remainder), LO (product low / quotient)
//   MulDiv_Valid           HI/LO valid for the instruction currently in EXE
//
// Optional: define MULDIV_EARLY_FINISH_EN to finish divides with a zero divisor or
// |A|<|B| in the accept cycle. DIV_ITERS must stay 32.
module mul_div_unit #(
    parameter int MUL_LATENCY = 2,
    parameter int DIV_ITERS   = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [2:0]  EXE_MulDivOp,
    input  logic [31:0] EXE_SrcA,
    input  logic [31:0] EXE_SrcB,
    input  logic        EXE_Wr,
    input  logic        Flush_Exception,
    output logic        DIVMULTBusy,
    output logic [31:0] MulDiv_Hi,
    output logic [31:0] MulDiv_Lo,
    output logic        MulDiv_Valid
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state;
    state_t      state_nxt;

    logic [4:0]  cnt;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        sgn_q;
    logic        a_neg_q;
    logic        b_neg_q;
    logic [31:0] quo_q;     // dividend shifts out of the top, quotient bits shift in
    logic [31:0] rem_q;
    logic [31:0] dvsr_q;    // divisor magnitude
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // ---------------- input decode ----------------
    logic        op_mul;
    logic        op_div;
    logic        op_vld;
    logic        op_sgn;
    logic        a_neg_in;
    logic        b_neg_in;
    logic [31:0] a_mag_in;
    logic [31:0] b_mag_in;
    logic        accept;
    logic        early_fin;

    always_comb begin
        op_mul   = (EXE_MulDivOp == OP_MULT) || (EXE_MulDivOp == OP_MULTU);
        op_div   = (EXE_MulDivOp == OP_DIV)  || (EXE_MulDivOp == OP_DIVU);
        op_vld   = op_mul || op_div;
        op_sgn   = (EXE_MulDivOp == OP_MULT) || (EXE_MulDivOp == OP_DIV);
        a_neg_in = op_sgn && EXE_SrcA[31];
        b_neg_in = op_sgn && EXE_SrcB[31];
        a_mag_in = a_neg_in ? -EXE_SrcA : EXE_SrcA;
        b_mag_in = b_neg_in ? -EXE_SrcB : EXE_SrcB;
        accept   = (state == IDLE) && op_vld && !Flush_Exception;
`ifdef MULDIV_EARLY_FINISH_EN
        // Quotient is trivially 0 (or all ones for /0) and the remainder is A itself.
        early_fin = op_div && ((b_mag_in == 32'd0) || (a_mag_in < b_mag_in));
`else
        early_fin = 1'b0;
`endif
    end

    // ---------------- one restoring divide step ----------------
    logic [32:0] rem_shift;
    logic [32:0] diff;
    logic [31:0] rem_step;
    logic [31:0] quo_step;
    logic [31:0] quo_fin;
    logic [31:0] rem_fin;

    always_comb begin
        rem_shift = {rem_q, quo_q[31]};
        diff      = rem_shift - {1'b0, dvsr_q};
        // diff[32] set means the trial subtraction went negative: restore.
        rem_step  = diff[32] ? rem_shift[31:0] : diff[31:0];
        quo_step  = {quo_q[30:0], ~diff[32]};
        quo_fin   = (a_neg_q ^ b_neg_q) ? -quo_step : quo_step;
        rem_fin   = a_neg_q ? -rem_step : rem_step;
    end

    // ---------------- multiply ----------------
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;

    always_comb begin
        a_ext = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        b_ext = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        // Low 64 bits of the sign-extended product are the exact signed/unsigned result.
        prod  = a_ext * b_ext;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (op_mul) begin
                        state_nxt = MUL;
                    end else if (early_fin) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = DIV;
                    end
                end
            end
            MUL:  if (cnt == 5'd0) state_nxt = DONE;
            DIV:  if (cnt == 5'd0) state_nxt = DONE;
            DONE: if (EXE_Wr) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (Flush_Exception) begin
            state_nxt = IDLE;
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt     <= 5'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            sgn_q   <= 1'b0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            quo_q   <= 32'd0;
            rem_q   <= 32'd0;
            dvsr_q  <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q     <= EXE_SrcA;
                        b_q     <= EXE_SrcB;
                        sgn_q   <= op_sgn;
                        a_neg_q <= a_neg_in;
                        b_neg_q <= b_neg_in;
                        quo_q   <= a_mag_in;
                        rem_q   <= 32'd0;
                        dvsr_q  <= b_mag_in;
                        cnt     <= op_mul ? 5'(MUL_LATENCY - 1) : 5'(DIV_ITERS - 1);
                        if (early_fin) begin
                            hi_q <= EXE_SrcA;
                            lo_q <= (b_mag_in == 32'd0) ? 32'hFFFF_FFFF : 32'd0;
                        end
                    end
                end
                MUL: begin
                    if (!Flush_Exception) begin
                        cnt <= cnt - 5'd1;
                        if (cnt == 5'd0) begin
                            hi_q <= prod[63:32];
                            lo_q <= prod[31:0];
                        end
                    end
                end
                DIV: begin
                    if (!Flush_Exception) begin
                        cnt   <= cnt - 5'd1;
                        quo_q <= quo_step;
                        rem_q <= rem_step;
                        if (cnt == 5'd0) begin
                            if (dvsr_q == 32'd0) begin
                                // Divide by zero reports the raw dividend and all-ones quotient.
                                hi_q <= a_q;
                                lo_q <= 32'hFFFF_FFFF;
                            end else begin
                                hi_q <= rem_fin;
                                lo_q <= quo_fin;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        DIVMULTBusy = resetn && !Flush_Exception &&
                      (((state == IDLE) && op_vld) || (state == MUL) || (state == DIV));
        MulDiv_Valid = (state == DONE);
        MulDiv_Hi    = hi_q;
        MulDiv_Lo    = lo_q;
    end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

    localparam int MUL_LATENCY = 2;

    logic        clk;
    logic        resetn;
    logic [2:0]  EXE_MulDivOp;
    logic [31:0] EXE_SrcA;
    logic [31:0] EXE_SrcB;
    logic        EXE_Wr;
    logic        Flush_Exception;
    logic        DIVMULTBusy;
    logic [31:0] MulDiv_Hi;
    logic [31:0] MulDiv_Lo;
    logic        MulDiv_Valid;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    mul_div_unit #(
        .MUL_LATENCY(MUL_LATENCY),
        .DIV_ITERS  (32)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .EXE_MulDivOp   (EXE_MulDivOp),
        .EXE_SrcA       (EXE_SrcA),
        .EXE_SrcB       (EXE_SrcB),
        .EXE_Wr         (EXE_Wr),
        .Flush_Exception(Flush_Exception),
        .DIVMULTBusy    (DIVMULTBusy),
        .MulDiv_Hi      (MulDiv_Hi),
        .MulDiv_Lo      (MulDiv_Lo),
        .MulDiv_Valid   (MulDiv_Valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain arithmetic on the architectural definition of each op.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output int busy);
        longint      sa;
        longint      sb;
        longint      ma;
        longint      mb;
        logic [63:0] p;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        busy = 1 + MUL_LATENCY;
        p    = 64'd0;
        case (op)
            3'd1: p = sa * sb;
            3'd2: p = {32'd0, a} * {32'd0, b};
            default: begin
                busy = 33;
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else if (op == 3'd3) begin
                    p = {32'(sa % sb), 32'(sa / sb)};
                end else begin
                    p = {a % b, a / b};
                end
`ifdef MULDIV_EARLY_FINISH_EN
                ma = (op == 3'd3) ? ((sa < 0) ? -sa : sa) : longint'(a);
                mb = (op == 3'd3) ? ((sb < 0) ? -sb : sb) : longint'(b);
                if (b == 32'd0 || ma < mb) busy = 1;
`else
                ma = 0;
                mb = 0;
`endif
            end
        endcase
        hi = p[63:32];
        lo = p[31:0];
    endtask

    // Issue one op, count busy cycles, check result, hold in DONE, then release.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit use_flush);
        logic [31:0] eh;
        logic [31:0] el;
        int          ebusy;
        int          nbusy;
        bit          vld_seen;
        model(op, a, b, eh, el, ebusy);
        next_cycle();
        EXE_MulDivOp    = op;
        EXE_SrcA        = a;
        EXE_SrcB        = b;
        EXE_Wr          = 1'b0;
        Flush_Exception = 1'b0;
        nbusy    = 0;
        vld_seen = 1'b0;
        @(negedge clk);
        while (DIVMULTBusy && nbusy < 100) begin
            if (MulDiv_Valid) vld_seen = 1'b1;
            nbusy++;
            next_cycle();
            // Operands are latched; anything on the inputs now must be ignored.
            EXE_MulDivOp = 3'($urandom_range(0, 7));
            EXE_SrcA     = $urandom;
            EXE_SrcB     = $urandom;
            @(negedge clk);
        end
        chk("busy_cycles", nbusy, ebusy);
        chk("valid_during_busy", vld_seen, 1'b0);
        chk("done_valid", MulDiv_Valid, 1'b1);
        chk("hi", MulDiv_Hi, eh);
        chk("lo", MulDiv_Lo, el);
        last_hi = eh;
        last_lo = el;
        for (int i = 0; i < hold; i++) begin
            next_cycle();
            @(negedge clk);
            chk("hold_valid", MulDiv_Valid, 1'b1);
            chk("hold_busy", DIVMULTBusy, 1'b0);
            chk("hold_hi", MulDiv_Hi, eh);
            chk("hold_lo", MulDiv_Lo, el);
        end
        next_cycle();
        EXE_MulDivOp    = 3'd0;
        EXE_Wr          = !use_flush;
        Flush_Exception = use_flush;
        @(negedge clk);
        chk("release_valid", MulDiv_Valid, 1'b1);
        chk("release_busy", DIVMULTBusy, 1'b0);
        next_cycle();
        EXE_Wr          = 1'b0;
        Flush_Exception = 1'b0;
        @(negedge clk);
        chk("idle_valid", MulDiv_Valid, 1'b0);
        chk("idle_busy", DIVMULTBusy, 1'b0);
        chk("idle_hi", MulDiv_Hi, eh);
    endtask

    initial begin
        bit          vld_seen;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        // Reset, with an op presented to prove Busy is held low.
        resetn          = 1'b0;
        EXE_MulDivOp    = 3'd1;
        EXE_SrcA        = 32'd5;
        EXE_SrcB        = 32'd6;
        EXE_Wr          = 1'b0;
        Flush_Exception = 1'b0;
        @(negedge clk);
        chk("rst_busy", DIVMULTBusy, 1'b0);
        @(negedge clk);
        chk("rst_hi", MulDiv_Hi, 32'd0);
        chk("rst_lo", MulDiv_Lo, 32'd0);
        chk("rst_valid", MulDiv_Valid, 1'b0);
        next_cycle();
        resetn       = 1'b1;
        EXE_MulDivOp = 3'd0;
        @(negedge clk);
        chk("post_rst_busy", DIVMULTBusy, 1'b0);
        last_hi = 32'd0;
        last_lo = 32'd0;

        // Directed cases.
        run_op(3'd4, 32'd100, 32'd7, 5, 1'b0);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1, 1'b0);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1'b1);
        run_op(3'd4, 32'd5, 32'd0, 0, 1'b0);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd0, 0, 1'b0);
        run_op(3'd3, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);

        // Flush presented together with an op in IDLE: nothing is accepted.
        next_cycle();
        EXE_MulDivOp    = 3'd4;
        EXE_SrcA        = 32'd9;
        EXE_SrcB        = 32'd2;
        Flush_Exception = 1'b1;
        @(negedge clk);
        chk("flush_idle_busy", DIVMULTBusy, 1'b0);
        next_cycle();
        EXE_MulDivOp    = 3'd0;
        Flush_Exception = 1'b0;
        @(negedge clk);
        chk("flush_idle_noacc", DIVMULTBusy, 1'b0);
        chk("flush_idle_valid", MulDiv_Valid, 1'b0);

        // DIV flushed on iteration 10.
        next_cycle();
        EXE_MulDivOp = 3'd3;
        EXE_SrcA     = 32'h7000_0000;
        EXE_SrcB     = 32'd3;
        @(negedge clk);
        chk("flush_acc_busy", DIVMULTBusy, 1'b1);
        for (int i = 1; i < 10; i++) begin
            next_cycle();
            @(negedge clk);
        end
        next_cycle();
        Flush_Exception = 1'b1;
        @(negedge clk);
        chk("flush_busy", DIVMULTBusy, 1'b0);
        next_cycle();
        Flush_Exception = 1'b0;
        EXE_MulDivOp    = 3'd0;
        @(negedge clk);
        chk("flush_next_busy", DIVMULTBusy, 1'b0);
        chk("flush_next_valid", MulDiv_Valid, 1'b0);
        chk("flush_hi", MulDiv_Hi, last_hi);
        chk("flush_lo", MulDiv_Lo, last_lo);
        vld_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            next_cycle();
            @(negedge clk);
            if (MulDiv_Valid) vld_seen = 1'b1;
        end
        chk("flush_never_valid", vld_seen, 1'b0);

        // Reset pulse in the last MUL cycle, when the product would otherwise land.
        next_cycle();
        EXE_MulDivOp = 3'd2;
        EXE_SrcA     = 32'h1234_5678;
        EXE_SrcB     = 32'h9ABC_DEF1;
        @(negedge clk);
        chk("rstmul_acc_busy", DIVMULTBusy, 1'b1);
        for (int i = 0; i < MUL_LATENCY; i++) begin
            next_cycle();
        end
        resetn       = 1'b0;
        EXE_MulDivOp = 3'd0;
        @(negedge clk);
        chk("rstmul_busy", DIVMULTBusy, 1'b0);
        next_cycle();
        resetn = 1'b1;
        @(negedge clk);
        chk("rstmul_hi", MulDiv_Hi, 32'd0);
        chk("rstmul_lo", MulDiv_Lo, 32'd0);
        chk("rstmul_valid", MulDiv_Valid, 1'b0);
        chk("rstmul_busy_after", DIVMULTBusy, 1'b0);
        run_op(3'd2, 32'd3, 32'd4, 0, 1'b0);

        // Randomized ops against the reference model.
        for (int n = 0; n < 24; n++) begin
            op = 3'($urandom_range(1, 4));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = a ^ 32'($urandom_range(0, 3));
                3:       begin a = 32'($urandom_range(0, 200)); b = $urandom; end
                default: b = $urandom;
            endcase
            run_op(op, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
